// File: rtl/support_exchange_unit.sv
// Link-side buffer for the support PE: queues ingress words, pops one per
// STAGE_WRITE_TO_MEM window into the PE, and returns the PE result on egress.
module support_exchange_unit #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STAGE_WIDTH   = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE         = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = STAGE_WIDTH'(4),
  localparam int unsigned EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3,
  localparam int unsigned CNT_W             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [STAGE_WIDTH-1:0]       global_stage,
  input  logic [EXPOSED_DATA_SIZE:0]   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [EXPOSED_DATA_SIZE-1:0] spu_input_data,
  output logic                         spu_do_not_store,
  input  logic [EXPOSED_DATA_SIZE-1:0] spu_output_data,
  output logic [EXPOSED_DATA_SIZE-1:0] tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [CNT_W-1:0]             fifo_count,
  output logic                         underflow_err,
  output logic                         overflow_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [STAGE_WIDTH-1:0]       stage_q, last_stage_q;
  logic [EXPOSED_DATA_SIZE:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [EXPOSED_DATA_SIZE-1:0] spu_data_q, spu_data_d;
  logic                         spu_dns_q, spu_dns_d;
  logic [EXPOSED_DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                         tx_valid_q, tx_valid_d;
  logic                         underflow_q, underflow_d;
  logic                         overflow_q, overflow_d;

  logic push, pop_evt, pop_ok, cap_evt, tx_fire;
  logic [EXPOSED_DATA_SIZE:0] head;

  assign rx_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push     = rx_valid && rx_ready;
  assign pop_evt  = (global_stage == STAGE_WRITE_TO_MEM) && (stage_q != STAGE_WRITE_TO_MEM);
  // Pop qualifies on the registered count, so a same-cycle push is never forwarded.
  assign pop_ok   = pop_evt && (count_q != '0);
  assign cap_evt  = (last_stage_q == STAGE_WRITE_TO_MEM) && (stage_q != STAGE_WRITE_TO_MEM);
  assign tx_fire  = tx_valid_q && tx_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    spu_data_d  = spu_data_q;
    spu_dns_d   = spu_dns_q;
    underflow_d = underflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_evt) begin
      if (pop_ok) begin
        spu_data_d = head[EXPOSED_DATA_SIZE-1:0];
        spu_dns_d  = head[EXPOSED_DATA_SIZE];
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end else begin
        spu_data_d  = '0;
        spu_dns_d   = 1'b1;
        underflow_d = 1'b1;
      end
    end
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overflow_d = overflow_q;
    if (tx_fire) tx_valid_d = 1'b0;
    if (cap_evt) begin
      if (!tx_valid_q || tx_fire) begin
        tx_data_d  = spu_output_data;
        tx_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q      <= STAGE_IDLE;
      last_stage_q <= STAGE_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      spu_data_q   <= '0;
      spu_dns_q    <= 1'b1;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      stage_q      <= global_stage;
      last_stage_q <= stage_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      spu_data_q   <= spu_data_d;
      spu_dns_q    <= spu_dns_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
    end
  end

  assign spu_input_data   = spu_data_q;
  assign spu_do_not_store = spu_dns_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign fifo_count       = count_q;
  assign underflow_err    = underflow_q;
  assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_support_exchange_unit.sv
// Directed bench for support_exchange_unit: FIFO ordering, window pop/capture,
// error flags, same-edge push/pop and asynchronous reset.
module tb_support_exchange_unit;

  localparam int unsigned AW  = 6;
  localparam int unsigned EDS = AW + 3;
  localparam int unsigned CW  = 3;
  localparam logic [2:0]  IDLE = 3'd0;
  localparam logic [2:0]  WTM  = 3'd4;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     global_stage;
  logic [EDS:0]   rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [EDS-1:0] spu_input_data;
  logic           spu_do_not_store;
  logic [EDS-1:0] spu_output_data;
  logic [EDS-1:0] tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [CW-1:0]  fifo_count;
  logic           underflow_err;
  logic           overflow_err;

  int checks = 0;
  int errors = 0;

  support_exchange_unit #(
    .ADDRESS_WIDTH(AW),
    .FIFO_DEPTH(4),
    .STAGE_WIDTH(3),
    .STAGE_IDLE(IDLE),
    .STAGE_WRITE_TO_MEM(WTM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .global_stage(global_stage),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .spu_input_data(spu_input_data),
    .spu_do_not_store(spu_do_not_store),
    .spu_output_data(spu_output_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fifo_count(fifo_count),
    .underflow_err(underflow_err),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [EDS:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  // L broadcast cycles of WRITE_TO_MEM, then two idle cycles so the capture lands.
  task automatic window(input int unsigned L);
    global_stage = WTM;
    repeat (L) cyc();
    global_stage = IDLE;
    repeat (2) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_valid = 1'b1;
    rx_data = 10'h155;
    repeat (4) cyc();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b expected 1", rx_ready); end
    checks++; if (spu_do_not_store !== 1'b1) begin errors++; $display("FAIL reset_dns got %b expected 1", spu_do_not_store); end
    checks++; if (spu_input_data !== 9'h000) begin errors++; $display("FAIL reset_spu_data got %h expected 000", spu_input_data); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 9'h000) begin errors++; $display("FAIL reset_tx_data got %h expected 000", tx_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", fifo_count); end
    checks++; if ({underflow_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b expected 00", {underflow_err, overflow_err}); end
    rx_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_release_count got %0d expected 0", fifo_count); end
  endtask

  task automatic test_basic();
    push_word(10'h0A5);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count_push got %0d expected 1", fifo_count); end
    tx_ready = 1'b0;
    spu_output_data = 9'h1C3;
    global_stage = WTM;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (spu_input_data !== 9'h0A5) begin errors++; $display("FAIL basic_spu_data[%0d] got %h expected 0a5", i, spu_input_data); end
      checks++; if (spu_do_not_store !== 1'b0) begin errors++; $display("FAIL basic_dns[%0d] got %b expected 0", i, spu_do_not_store); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL basic_count_pop[%0d] got %0d expected 0", i, fifo_count); end
    end
    global_stage = IDLE;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_tx_early got %b expected 0", tx_valid); end
    cyc();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL basic_tx_valid got %b expected 1", tx_valid); end
    checks++; if (tx_data !== 9'h1C3) begin errors++; $display("FAIL basic_tx_data got %h expected 1c3", tx_data); end
    tx_ready = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_tx_drain got %b expected 0", tx_valid); end
  endtask

  task automatic test_fill_wrap();
    logic [EDS:0] w [5];
    w[0] = 10'h011; w[1] = 10'h222; w[2] = 10'h033; w[3] = 10'h244; w[4] = 10'h055;
    for (int i = 0; i < 5; i++) begin
      rx_data  = w[i];
      rx_valid = 1'b1;
      cyc();
    end
    rx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d expected 4", fifo_count); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL fill_rx_ready got %b expected 0", rx_ready); end
    for (int i = 0; i < 4; i++) begin
      window(1);
      checks++; if (spu_input_data !== w[i][EDS-1:0]) begin errors++; $display("FAIL fill_pop_data[%0d] got %h expected %h", i, spu_input_data, w[i][EDS-1:0]); end
      checks++; if (spu_do_not_store !== w[i][EDS]) begin errors++; $display("FAIL fill_pop_dns[%0d] got %b expected %b", i, spu_do_not_store, w[i][EDS]); end
      checks++; if (fifo_count !== CW'(3 - i)) begin errors++; $display("FAIL fill_pop_count[%0d] got %0d expected %0d", i, fifo_count, 3 - i); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL fill_pop_ready[%0d] got %b expected 1", i, rx_ready); end
    end
  endtask

  task automatic test_underflow();
    window(1);
    checks++; if (spu_input_data !== 9'h000) begin errors++; $display("FAIL uf_data got %h expected 000", spu_input_data); end
    checks++; if (spu_do_not_store !== 1'b1) begin errors++; $display("FAIL uf_dns got %b expected 1", spu_do_not_store); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_flag got %b expected 1", underflow_err); end
    repeat (10) cyc();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b expected 1", underflow_err); end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL of_pre_valid got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    spu_output_data = 9'h1AB;
    window(2);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL of_first_valid got %b expected 1", tx_valid); end
    checks++; if (tx_data !== 9'h1AB) begin errors++; $display("FAIL of_first_data got %h expected 1ab", tx_data); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL of_first_flag got %b expected 0", overflow_err); end
    spu_output_data = 9'h0CD;
    window(1);
    checks++; if (tx_data !== 9'h1AB) begin errors++; $display("FAIL of_hold_data got %h expected 1ab", tx_data); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL of_flag got %b expected 1", overflow_err); end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL of_drain got %b expected 0", tx_valid); end
    tx_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    push_word(10'h101);
    push_word(10'h102);
    tx_ready = 1'b0;
    spu_output_data = 9'h077;
    window(1);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL ar_pre_count got %0d expected 1", fifo_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d expected 0", fifo_count); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ar_tx_valid got %b expected 0", tx_valid); end
    checks++; if (spu_do_not_store !== 1'b1) begin errors++; $display("FAIL ar_dns got %b expected 1", spu_do_not_store); end
    checks++; if ({underflow_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL ar_errs got %b expected 00", {underflow_err, overflow_err}); end
    cyc();
    reset = 1'b1;
    tx_ready = 1'b1;
    cyc();
  endtask

  task automatic test_push_pop_same_edge();
    rx_data = 10'h0E7;
    rx_valid = 1'b1;
    global_stage = WTM;
    cyc();
    rx_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count got %0d expected 1", fifo_count); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL pp_uf got %b expected 1", underflow_err); end
    checks++; if (spu_do_not_store !== 1'b1) begin errors++; $display("FAIL pp_dns got %b expected 1", spu_do_not_store); end
    global_stage = IDLE;
    repeat (2) cyc();
    window(1);
    checks++; if (spu_input_data !== 9'h0E7) begin errors++; $display("FAIL pp_next_data got %h expected 0e7", spu_input_data); end
    checks++; if (spu_do_not_store !== 1'b0) begin errors++; $display("FAIL pp_next_dns got %b expected 0", spu_do_not_store); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pp_next_count got %0d expected 0", fifo_count); end
  endtask

  initial begin
    global_stage = IDLE;
    rx_data = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    spu_output_data = '0;
    test_reset();
    test_basic();
    test_fill_wrap();
    test_underflow();
    test_overflow();
    test_async_reset();
    test_push_pop_same_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/support_exchange_unit.md
# support_exchange_unit

Ingress/egress buffer in front of `support_processing_unit`. It accepts boundary-vertex words from the inter-FPGA link on a valid/ready handshake and queues them in a small FIFO. On each STAGE_WRITE_TO_MEM window it pops one word and drives `input_data`/`do_not_store` to the support PE. After the window closes it captures the PE's `output_data` and offers it back to the link on a second valid/ready handshake.

## Interface
- `ADDRESS_WIDTH`, 6, vertex address width; `EXPOSED_DATA_SIZE = ADDRESS_WIDTH+3` (localparam).
- `FIFO_DEPTH`, 4, ingress FIFO entries; power of two, ≥2. `CNT_W = $clog2(FIFO_DEPTH)+1` (localparam).
- `STAGE_WIDTH` and the stage codes come from the shared parameters include.
- `clk` in 1 — single clock, all logic on posedge.
- `reset` in 1 — asynchronous, active-low; block held in reset while `reset==0`.
- `global_stage` in STAGE_WIDTH — decoder stage broadcast.
- `rx_data` in EXPOSED_DATA_SIZE+1 — bit[EXPOSED_DATA_SIZE] is the bypass flag; the lower bits are the exposed word.
- `rx_valid` in 1, `rx_ready` out 1 — ingress handshake.
- `spu_input_data` out EXPOSED_DATA_SIZE — to PE `input_data`.
- `spu_do_not_store` out 1 — to PE `do_not_store`.
- `spu_output_data` in EXPOSED_DATA_SIZE — from PE `output_data`.
- `tx_data` out EXPOSED_DATA_SIZE, `tx_valid` out 1, `tx_ready` in 1 — egress handshake.
- `fifo_count` out CNT_W — current ingress occupancy.
- `underflow_err` out 1, `overflow_err` out 1 — sticky error flags.

## Operation
- Internal registers `stage <= global_stage` and `last_stage <= stage` mirror the PE exactly. Both reset to STAGE_IDLE.
- Ingress FIFO:
  - Circular buffer with read and write pointers plus an occupancy count.
  - `rx_ready = (fifo_count != FIFO_DEPTH)`.
  - Push on `rx_valid && rx_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop event: `global_stage==STAGE_WRITE_TO_MEM && stage!=STAGE_WRITE_TO_MEM`, i.e. the first cycle of the window as seen on the broadcast.
  - Non-empty FIFO: register the head word's low bits into `spu_input_data` and the bypass bit into `spu_do_not_store`, then advance the read pointer.
  - Empty FIFO: `spu_input_data <= 0`, `spu_do_not_store <= 1`, set `underflow_err`.
- `spu_input_data` and `spu_do_not_store` hold their values until the next pop event. They are stable for the whole PE write window.
- Simultaneous push and pop: the count is unchanged. A push into an empty FIFO in the same cycle as a pop is not forwarded; that pop underflows and the pushed word stays queued.
- Capture event: `last_stage==STAGE_WRITE_TO_MEM && stage!=STAGE_WRITE_TO_MEM`.
  - `tx_valid==0`, or `tx_valid && tx_ready` in the same cycle: `tx_data <= spu_output_data`, `tx_valid <= 1`.
  - Otherwise drop the new word, keep the old `tx_data`, set `overflow_err`.
- `tx_valid` clears on `tx_valid && tx_ready` unless a capture occurs in the same cycle. `tx_data` never changes while `tx_valid && !tx_ready`.
- Error flags clear only on reset.

## Timing
- Reset values:
  - `stage`, `last_stage` = STAGE_IDLE.
  - FIFO empty, `fifo_count=0`, so `rx_ready=1`.
  - `spu_input_data=0`, `spu_do_not_store=1`.
  - `tx_data=0`, `tx_valid=0`.
  - Both error flags = 0.
- Reset asserted mid-transfer discards all queued and held words immediately, without waiting for a clock edge.
- Ingress latency: a word accepted at edge N is poppable from edge N+1.
- Pop-to-PE: the pop is evaluated at edge E, where `global_stage` first shows WRITE_TO_MEM. The PE `stage` also becomes WRITE_TO_MEM at E, so the PE sees the new data for its entire window.
- A window of L cycles on `global_stage` produces exactly one pop. Back-to-back windows separated by ≥1 non-write cycle each pop once.
- Capture: a window last seen on `global_stage` at cycle C gives PE `output_data` final at edge C+2. The capture is evaluated at edge C+2 and `tx_valid` rises after edge C+2.
- `fifo_count` and `rx_ready` update on the edge following a push or pop; there is no combinational ready→valid path.

## Test plan
- Reset with `rx_valid=1` → `rx_ready=1`, `spu_do_not_store=1`, `tx_valid=0`, `fifo_count=0`; no push until `reset` deasserts.
- Push 0x0A5 (bypass=0); 3-cycle WRITE_TO_MEM window → `spu_input_data=0x0A5` and `spu_do_not_store=0` for all 3 PE cycles; `fifo_count` 1→0; afterwards `tx_valid=1` with `tx_data` equal to PE `output_data`.
- Push 5 words with FIFO_DEPTH=4 and no windows → 4 accepted, `rx_ready=0` at count 4. One window pops word 1 and `rx_ready` returns to 1. Three further windows return words 2-4 in order across pointer wrap-around.
- Window with empty FIFO → `spu_input_data=0`, `spu_do_not_store=1`, `underflow_err=1` and still 1 after 10 further cycles.
- Hold `tx_ready=0` across two windows → first captured word retained, `overflow_err=1`. Raising `tx_ready` for one cycle drops `tx_valid` to 0.
- Push into an empty FIFO on the same edge as a pop → underflow flagged, `fifo_count=1`, and the word is delivered on the next window.
